// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame-format defaults,
// common to uart_rx and uart_tx.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS            = 8;
   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset never looks like a start bit.
module uart_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, and a
// stop-bit check that returns to idle at the stop midpoint.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_busy,
   output logic                 rx_done,
   output logic                 frame_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic                 line;
   logic                 line_prev_q;
   uart_state_e          state_q,  state_d;
   logic [CNT_W-1:0]     baud_q,   baud_d;
   logic [BIT_W-1:0]     bit_q,    bit_d;
   logic [DATA_BITS-1:0] shift_q,  shift_d;
   logic [DATA_BITS-1:0] data_q,   data_d;
   logic                 done_q,   done_d;
   logic                 err_q,    err_d;

   uart_sync2 u_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (rx),
      .q_o   (line)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         line_prev_q <= 1'b1;
         state_q     <= ST_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         line_prev_q <= line;
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            // Edge-triggered so a line stuck low after a framing error cannot restart.
            if (line_prev_q && !line) begin
               state_d = ST_START;
               bit_d   = '0;
            end
         end

         ST_START: begin
            if (baud_q == BAUD_HALF) begin
               baud_d  = '0;
               state_d = line ? ST_IDLE : ST_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {line, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = ST_IDLE;
               if (line) begin
                  data_d = shift_q;
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign rx_data   = data_q;
   assign rx_busy   = (state_q != ST_IDLE);
   assign rx_done   = done_q;
   assign frame_err = err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a frame-level scoreboard of expected bytes and pulses.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int LAT = 2 + (19 * CPB) / 2 + 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_busy;
   logic       rx_done;
   logic       frame_err;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_busy   (rx_busy),
      .rx_done   (rx_done),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          busy_cyc = 0;
   int          busy_rises = 0;
   logic        busy_prev = 1'b0;
   logic [7:0]  exp_data = '0;
   logic [7:0]  exp_q[$];
   int unsigned start_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Drives one 8N1 frame starting at a negedge; good frames go on the scoreboard.
   task automatic send(input logic [7:0] b, input logic stop);
      if (stop) begin
         exp_q.push_back(b);
         start_q.push_back(cyc);
      end
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int unsigned i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   // Per-cycle monitor, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (reset) begin
         chk("rst_busy", 32'(rx_busy), 32'd0);
         chk("rst_done", 32'(rx_done), 32'd0);
         chk("rst_err", 32'(frame_err), 32'd0);
         chk("rst_data", 32'(rx_data), 32'd0);
         exp_data = '0;
      end else begin
         chk("done_err_exclusive", 32'(rx_done & frame_err), 32'd0);
         if (rx_done || frame_err) chk("busy_falls_with_pulse", 32'(rx_busy), 32'd0);
         if (frame_err) err_cnt++;
         if (rx_done) begin
            done_cnt++;
            chk("done_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_data = exp_q.pop_front();
               chk("rx_data_at_done", 32'(rx_data), 32'(exp_data));
               chk_range("latency", int'(cyc - start_q.pop_front()), LAT - 1, LAT + 1);
            end
         end
         chk("rx_data_model", 32'(rx_data), 32'(exp_data));
      end
      if (rx_busy) busy_cyc++;
      if (rx_busy && !busy_prev) busy_rises++;
      busy_prev = rx_busy;
   end

   initial begin
      int d0, e0, b0, r0;
      int n_good, n_bad;
      logic [7:0] rb;
      logic       good;

      repeat (3) @(negedge clk);
      chk("reset_data", 32'(rx_data), 32'd0);
      chk("reset_busy", 32'(rx_busy), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Single good frame
      d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
      send(8'hA5, 1'b1);
      repeat (20) @(negedge clk);
      chk("a5_done_count", 32'(done_cnt - d0), 32'd1);
      chk("a5_err_count", 32'(err_cnt - e0), 32'd0);
      chk("a5_data", 32'(rx_data), 32'hA5);
      chk_range("a5_busy_cycles", busy_cyc - b0, 9 * CPB + CPB / 2 - 1, 9 * CPB + CPB / 2 + 1);

      // Short glitch: start qualified then rejected at midpoint
      d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc; r0 = busy_rises;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_busy_rises", 32'(busy_rises - r0), 32'd1);
      chk_range("glitch_busy_cycles", busy_cyc - b0, CPB / 2 - 2, CPB / 2 + 2);
      chk("glitch_done", 32'(done_cnt - d0), 32'd0);
      chk("glitch_err", 32'(err_cnt - e0), 32'd0);
      chk("glitch_data", 32'(rx_data), 32'hA5);

      // Bad stop bit
      d0 = done_cnt; e0 = err_cnt;
      send(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      chk("badstop_err", 32'(err_cnt - e0), 32'd1);
      chk("badstop_done", 32'(done_cnt - d0), 32'd0);
      chk("badstop_data", 32'(rx_data), 32'hA5);

      // Line held low (break), then a good frame
      d0 = done_cnt; e0 = err_cnt; r0 = busy_rises;
      rx = 1'b0;
      repeat (30 * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("break_err", 32'(err_cnt - e0), 32'd1);
      chk("break_no_retrigger", 32'(busy_rises - r0), 32'd1);
      chk("break_done", 32'(done_cnt - d0), 32'd0);
      send(8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      chk("after_break_done", 32'(done_cnt - d0), 32'd1);
      chk("after_break_data", 32'(rx_data), 32'h5A);

      // Back-to-back frames with no idle gap
      d0 = done_cnt; e0 = err_cnt;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      repeat (20) @(negedge clk);
      chk("b2b_done", 32'(done_cnt - d0), 32'd2);
      chk("b2b_err", 32'(err_cnt - e0), 32'd0);
      chk("b2b_data", 32'(rx_data), 32'hFF);

      // Reset in the middle of bit 3 of 0x81; sender goes idle with reset
      d0 = done_cnt; e0 = err_cnt;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int unsigned i = 0; i < 3; i++) begin
         rx = (i == 0);
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      chk("midreset_busy_before", 32'(rx_busy), 32'd1);
      reset = 1'b1;
      rx    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_busy_after", 32'(rx_busy), 32'd0);
      repeat (12 * CPB) @(negedge clk);
      chk("midreset_done", 32'(done_cnt - d0), 32'd0);
      chk("midreset_err", 32'(err_cnt - e0), 32'd0);
      chk("midreset_idle", 32'(rx_busy), 32'd0);
      send(8'h42, 1'b1);
      repeat (20) @(negedge clk);
      chk("midreset_next_done", 32'(done_cnt - d0), 32'd1);
      chk("midreset_next_data", 32'(rx_data), 32'h42);

      // Random frames with random gaps and occasional bad stop bits
      d0 = done_cnt; e0 = err_cnt;
      n_good = 0; n_bad = 0;
      for (int unsigned k = 0; k < 12; k++) begin
         rb   = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send(rb, good);
         if (good) begin
            n_good++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end else begin
            n_bad++;
            repeat ($urandom_range(3, 6)) @(negedge clk);
         end
      end
      repeat (40) @(negedge clk);
      chk("rand_done_count", 32'(done_cnt - d0), 32'(n_good));
      chk("rand_err_count", 32'(err_cnt - e0), 32'(n_bad));
      chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_rx
